// File: rtl/echo_acq_packer.sv
// echo_acq_packer: write-side producer for the acquisition byte FIFO.
// A trigger sends one header byte, then runs the pulse, damp and listen-delay
// phases, then captures num_samples decimated ADC samples as tagged byte pairs.
// Tag bits: 11 = header, 10 = sample high byte, 01 = sample low byte.
module echo_acq_packer #(
   parameter int ADC_BITS = 10,
   parameter int DECIM    = 4,
   parameter int NS_W     = 16
) (
   input  logic                wr_clk,
   input  logic                reset,
   input  logic                trigger,
   input  logic [7:0]          pulse_len,
   input  logic [7:0]          damp_len,
   input  logic [15:0]         delay_len,
   input  logic [NS_W-1:0]     num_samples,
   input  logic [ADC_BITS-1:0] adc_data,
   input  logic                full,
   output logic                wr_en,
   output logic [7:0]          wr_data,
   output logic                pulse_on,
   output logic                damp_on,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [7:0]          drop_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PULSE, S_DAMP, S_DELAY, S_ACQ} state_t;

   localparam logic [7:0] DLAST = 8'(DECIM - 1);

   state_t                state_q, state_d;
   logic [5:0]            seq_q, seq_d;
   logic [7:0]            plen_q, plen_d;
   logic [7:0]            dlen_q, dlen_d;
   logic [15:0]           dly_q, dly_d;
   logic [NS_W-1:0]       ns_q, ns_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [7:0]            dcnt_q, dcnt_d;
   logic [NS_W-1:0]       scnt_q, scnt_d;
   logic [ADC_BITS-1:0]   sample_q, sample_d;
   logic [3:0]            hold_q, hold_d;
   logic                  ovf_q, ovf_d;
   logic [7:0]            drop_q, drop_d;
   logic                  done_q, done_d;
   logic                  req;
   logic [7:0]            req_data;

   // Where each phase hands over to; zero-length phases are skipped outright.
   state_t to_acq, to_dly, to_damp, to_pulse;
   assign to_acq   = (ns_q   != '0) ? S_ACQ   : S_IDLE;
   assign to_dly   = (dly_q  != '0) ? S_DELAY : to_acq;
   assign to_damp  = (dlen_q != '0) ? S_DAMP  : to_dly;
   assign to_pulse = (plen_q != '0) ? S_PULSE : to_damp;

   // Next-state, counters, byte requests and drop accounting.
   always_comb begin
      state_d  = state_q;
      seq_d    = seq_q;
      plen_d   = plen_q;
      dlen_d   = dlen_q;
      dly_d    = dly_q;
      ns_d     = ns_q;
      cnt_d    = cnt_q;
      dcnt_d   = dcnt_q;
      scnt_d   = scnt_q;
      sample_d = adc_data;
      hold_d   = hold_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      req      = 1'b0;
      req_data = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               plen_d  = pulse_len;
               dlen_d  = damp_len;
               dly_d   = delay_len;
               ns_d    = num_samples;
               ovf_d   = 1'b0;
               drop_d  = 8'h00;
               state_d = S_HEADER;
            end
         end
         S_HEADER: begin
            req      = 1'b1;
            req_data = {2'b11, seq_q};
            seq_d    = seq_q + 6'd1;
            cnt_d    = '0;
            dcnt_d   = '0;
            scnt_d   = '0;
            state_d  = to_pulse;
         end
         S_PULSE: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == {8'h00, plen_q - 8'd1}) begin
               cnt_d   = '0;
               state_d = to_damp;
            end
         end
         S_DAMP: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == {8'h00, dlen_q - 8'd1}) begin
               cnt_d   = '0;
               state_d = to_dly;
            end
         end
         S_DELAY: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == dly_q - 16'd1) begin
               cnt_d   = '0;
               state_d = to_acq;
            end
         end
         S_ACQ: begin
            if (dcnt_q == 8'd0) begin
               req      = 1'b1;
               req_data = {2'b10, sample_q[9:4]};
               hold_d   = sample_q[3:0];
            end
            if (dcnt_q == 8'd1) begin
               req      = 1'b1;
               req_data = {4'b0100, hold_q};
               scnt_d   = scnt_q + NS_W'(1);
            end
            // A sample slot always runs its full DECIM cycles before exit.
            if (dcnt_q == DLAST) begin
               dcnt_d = '0;
               if (scnt_d == ns_q) state_d = S_IDLE;
            end else begin
               dcnt_d = dcnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Timing never stalls on full; the byte is simply lost and counted.
      if (req && full) begin
         ovf_d  = 1'b1;
         drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
      end
      done_d = (state_d == S_IDLE) && (state_q != S_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         seq_q    <= '0;
         plen_q   <= '0;
         dlen_q   <= '0;
         dly_q    <= '0;
         ns_q     <= '0;
         cnt_q    <= '0;
         dcnt_q   <= '0;
         scnt_q   <= '0;
         sample_q <= '0;
         hold_q   <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         seq_q    <= seq_d;
         plen_q   <= plen_d;
         dlen_q   <= dlen_d;
         dly_q    <= dly_d;
         ns_q     <= ns_d;
         cnt_q    <= cnt_d;
         dcnt_q   <= dcnt_d;
         scnt_q   <= scnt_d;
         sample_q <= sample_d;
         hold_q   <= hold_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
         done_q   <= done_d;
      end
   end

   assign wr_en    = req & ~full & ~reset;
   assign wr_data  = req_data;
   assign pulse_on = (state_q == S_PULSE);
   assign damp_on  = (state_q == S_DAMP);
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign overflow = ovf_q;
   assign drop_cnt = drop_q;

endmodule

// File: doc/echo_acq_packer.md
Name: echo_acq_packer

Overview:
- Write-side producer for the byte-wide async FIFO (8-deep, 8-bit) in the pulse-echo acquisition path. Runs in the wr_clk domain.
- On trigger it:
  - emits a header byte,
  - sequences the transducer pulse, damp and listen-delay phases,
  - captures NS decimated ADC samples and packs each one into two tagged bytes.
- Bytes go straight into the FIFO write port. The FIFO read side, on rd_clk, drains them to the host.

Parameters:
ADC_BITS, 10, ADC sample width; fixed at 10 by the packing format
DECIM, 4, wr_clk cycles per ADC sample; legal range 2..255
NS_W, 16, width of the sample-count input and counter

Ports:
wr_clk  in  1  write-domain clock
reset  in  1  synchronous, active-high
trigger  in  1  start request, synchronous to wr_clk, level-sampled
pulse_len  in  8  PULSE phase length in cycles, latched at start
damp_len  in  8  DAMP phase length in cycles, latched at start
delay_len  in  16  DELAY phase length in cycles, latched at start
num_samples  in  NS_W  samples to capture, latched at start
adc_data  in  10  ADC sample bus
full  in  1  FIFO full flag, wr_clk domain
wr_en  out  1  FIFO write enable
wr_data  out  8  FIFO write data
pulse_on  out  1  transducer drive
damp_on  out  1  transducer damping switch
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse on return to IDLE
overflow  out  1  sticky: at least one byte was dropped this acquisition
drop_cnt  out  8  bytes dropped this acquisition, saturates at 255

Behaviour:
- Reset (synchronous, active-high, wr_clk), including mid-operation:
  - state goes to IDLE;
  - all outputs go to 0;
  - the 6-bit sequence counter seq, the phase counters, sample_r and hold_r go to 0;
  - no FIFO write occurs in the reset cycle.
- adc_data is registered into sample_r on every wr_clk edge (1-cycle input pipeline).
- States and transitions:
  - IDLE: trigger=1 at an edge latches the four length inputs, clears overflow and drop_cnt, and moves to HEADER. A trigger while busy is ignored.
  - HEADER: lasts 1 cycle. Write request with wr_data = {2'b11, seq}. seq increments at the exit edge and wraps 63 -> 0.
  - PULSE: pulse_on=1 for exactly pulse_len cycles.
  - DAMP: damp_on=1 for exactly damp_len cycles.
  - DELAY: idle for delay_len cycles.
  - ACQ: decimation counter dcnt runs 0..DECIM-1 and restarts at 0 on ACQ entry.
    - dcnt==0: write request with wr_data = {2'b10, sample_r[9:4]}; hold_r <= sample_r.
    - dcnt==1: write request with wr_data = {4'b0100, hold_r[3:0]}.
    - The sample count increments at the edge ending dcnt==1.
    - ACQ exits after num_samples samples.
  - done=1 during the first IDLE cycle after ACQ.
- Zero lengths:
  - A phase with length 0 is skipped in 0 cycles; the next nonzero phase follows HEADER directly.
  - num_samples=0 gives HEADER, then the phases, then IDLE with no sample bytes.
- pulse_on and damp_on are never high together, and are never high outside their own state.
- The state machine ignores full; the phase and sample timing is fixed.
  - wr_en = write_request & ~full (combinational). wr_data is valid whenever a write is requested.
  - A request while full=1 drops that byte: overflow is set, and drop_cnt increments with saturation. There is no retry.
- The byte stream per acquisition is 1 header byte plus 2·num_samples bytes. Tag bits: 11 = header, 10 = sample high byte, 01 = sample low byte.
- A trigger held high re-arms: with trigger high in the done cycle, the edge ending the done cycle starts a new acquisition.

Test Plan:
- Reset then idle, trigger=0 for 20 cycles -> all outputs 0, no wr_en.
- DECIM=4, pulse=3, damp=2, delay=5, ns=3, adc_data constant 10'h2A5, full=0:
  - exactly 7 writes: C0, A A, 45, A A, 45, A A, 45;
  - pulse_on high 3 cycles, then damp_on high 2 cycles;
  - done 1 cycle; busy low afterwards.
- Back-to-back triggers (trigger held high): second header = C1; after 64 acquisitions seq wraps to C0.
- full forced high during the 2nd sample's two bytes, ns=3:
  - only 5 bytes written;
  - overflow=1, drop_cnt=2;
  - both cleared by the next trigger.
- pulse_len=0, damp_len=0, delay_len=0, ns=0 -> header byte only, then done.
- Reset asserted mid-ACQ with 2 samples emitted -> next cycle is IDLE with all outputs 0 and seq=0; a fresh trigger produces header C0.
